// File: rtl/enc_pkg.sv
// Shared types and helpers for the serial priority encoder.
// Holds the FSM state type and the index-width rule used by every file.
package enc_pkg;

    typedef enum logic [0:0] {
        ENC_IDLE = 1'b0,
        ENC_SCAN = 1'b1
    } enc_state_t;

    // Index width for an n-bit vector; a 1-bit vector still needs one index bit.
    function automatic int enc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lsb_prio_enc.sv
// Combinational lowest-set-bit encoder: index, isolating one-hot mask,
// and a flag saying whether any other bit remains set.
module lsb_prio_enc
    import enc_pkg::*;
#(
    parameter int  N = 8,
    localparam int W = enc_idx_w(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot,
    output logic         multi
);

    logic found;

    // NOTE: every output gets a default before the loop, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        idx    = '0;
        onehot = '0;
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i] && !found) begin
                idx       = W'(i);
                onehot[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign multi = |(vec & ~onehot);

endmodule

// File: rtl/prio_enc_serial.sv
// Serial priority encoder: loads an N-bit vector and emits the index of each
// set bit, lowest first. Define ENC_ZERO_ERR_EN to flag zero loads on dout_err.
module prio_enc_serial
    import enc_pkg::*;
#(
    parameter int  N = 8,
    localparam int W = enc_idx_w(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic [W-1:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         dout_last,
    output logic         busy
`ifdef ENC_ZERO_ERR_EN
   ,output logic         dout_err
`endif
);

    enc_state_t   state_q, state_d;
    logic [N-1:0] pend_q,  pend_d;

    logic [W-1:0] enc_idx;
    logic [N-1:0] enc_onehot;
    logic         enc_multi;

`ifdef ENC_ZERO_ERR_EN
    logic         err_q,   err_d;
`endif

    lsb_prio_enc #(
        .N      (N)
    ) u_lsb (
        .vec    (pend_q),
        .idx    (enc_idx),
        .onehot (enc_onehot),
        .multi  (enc_multi)
    );

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
`ifdef ENC_ZERO_ERR_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            ENC_IDLE: begin
                if (din_valid) begin
                    if (din != '0) begin
                        pend_d  = din;
                        state_d = ENC_SCAN;
                    end
`ifdef ENC_ZERO_ERR_EN
                    else begin
                        // Zero load: one error beat with an empty pend (index 0, last).
                        state_d = ENC_SCAN;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            ENC_SCAN: begin
                if (dout_ready) begin
                    pend_d = pend_q & ~enc_onehot;
                    if (!enc_multi) begin
                        state_d = ENC_IDLE;
`ifdef ENC_ZERO_ERR_EN
                        err_d   = 1'b0;
`endif
                    end
                end
            end
            default: state_d = ENC_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other; pend is a plain register and
    // is reset with the FSM so a mid-scan reset discards it immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENC_IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

`ifdef ENC_ZERO_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign dout_err   = (state_q == ENC_SCAN) && err_q;
`endif

    // All outputs decode from registers only.
    assign din_ready  = (state_q == ENC_IDLE);
    assign busy       = (state_q == ENC_SCAN);
    assign dout_valid = (state_q == ENC_SCAN);
    assign dout       = (state_q == ENC_SCAN) ? enc_idx : '0;
    assign dout_last  = (state_q == ENC_SCAN) && !enc_multi;

endmodule
